icache: RTL
===========

Name: icache

Overview:
- Direct-mapped instruction cache between the instruction-fetch stage (downstream consumer) and the memory controller (upstream word-fetch source).
- Accepts one PC request at a time from fetch and returns the 32-bit instruction as a one-cycle pulse.
- A hit answers in 1 cycle; a miss issues a word read to the memory controller, fills the line, then answers.
- Supports a flush that cancels a pending answer after a branch mispredict.

Parameters:
- IDX_W, 8, index bits; the cache holds 2^IDX_W lines of one 32-bit word each.
- TAG_W, 32-IDX_W-2, tag bits taken from PC[31:IDX_W+2].

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global ready; when 0, all registers hold their value.
- iIF_En  in  1  fetch request strobe.
- iIF_Pc  in  32  request PC; bits [1:0] are ignored.
- oIF_En  out  1  one-cycle pulse: instruction valid.
- oIF_Ins  out  32  instruction word.
- oMC_En  out  1  memory read request; level signal, held until acknowledged.
- oMC_Addr  out  32  word address, {PC[31:2],2'b00}.
- iMC_En  in  1  memory data valid; one-cycle pulse.
- iMC_Dat  in  32  fetched word.
- iFlush  in  1  mispredict flush from the ROB.

Behaviour:
- Reset (rst=0, asynchronous):
  - all valid bits cleared; state=IDLE.
  - oIF_En=0, oIF_Ins=0, oMC_En=0, oMC_Addr=0, drop=0.
  - tag and data arrays are not reset.
- All sequential updates below apply only when rst=1 and en=1.
- oIF_En defaults to 0 every active cycle (pulse semantics).
- State IDLE:
  - iIF_En=1 and iFlush=0:
    - Hit (valid[idx] and tag[idx]==PC tag): next edge oIF_En=1, oIF_Ins=data[idx]; stay IDLE.
    - Miss: latch PC; oMC_En=1, oMC_Addr={PC[31:2],2'b00}; go to MISS.
- State MISS:
  - oMC_En stays 1 until iMC_En=1 is sampled.
  - On iMC_En=1, at that edge:
    - write data[idx]=iMC_Dat, tag[idx]=tag, valid[idx]=1;
    - oMC_En=0;
    - if drop=0: oIF_En=1, oIF_Ins=iMC_Dat;
    - clear drop; go to IDLE.
  - Miss latency = memory latency + 1 cycle.
- iIF_En while in MISS is ignored; fetch guarantees it does not occur.
- iFlush=1:
  - In IDLE: any same-cycle iIF_En is dropped (flush wins); no response is produced.
  - In MISS: set drop=1; the fill still completes (the line becomes valid) but oIF_En is not pulsed.
  - iFlush together with iMC_En: the line is filled and oIF_En=0.
  - A pulse already registered on oIF_En is not retracted; fetch discards it on flush.
- Index = PC[IDX_W+1:2]. Tag comparison is full TAG_W width.
- Addresses wrap naturally at 32 bits; no special case.
- Reset mid-miss: returns to IDLE with oMC_En=0; the memory controller is reset by the same rst.
- A read of a line being filled in the same cycle is impossible (single outstanding request).

Decomposition:
- Shared header.vh: REG_DAT_W=32, INS_DAT_W=32, and opcode constants already used by fetch.
- Local constants: state encoding IDLE=0, MISS=1.
- Sub-module icache_array: holds the valid/tag/data arrays.
  - Combinational read port: hit, data.
  - Synchronous write port.
  - Valid bits use asynchronous active-low clear.
- Top level holds the FSM, the request latch and the drop flag.

Test Plan:
- Cold miss:
  - Stimulus: rst released; iIF_En with PC=0x0000_0000; memory returns 0x0000_0513 after 3 cycles.
  - Response: oMC_En=1 with oMC_Addr=0x0; oMC_En held for 3 cycles; oIF_En=1 and oIF_Ins=0x0000_0513 exactly 1 cycle after iMC_En; oMC_En=0.
- Hit:
  - Stimulus: re-request PC=0x0.
  - Response: oIF_En=1 next cycle, oIF_Ins=0x0000_0513; oMC_En stays 0.
- Conflict eviction (IDX_W=8):
  - Stimulus: fill PC=0x0004, then request PC=0x0404.
  - Response: the second request misses and refills; a third request to 0x0004 misses again.
- Flush during miss:
  - Stimulus: request PC=0x0010; pulse iFlush while oMC_En=1; memory returns 0xDEAD_BEEF.
  - Response: oIF_En stays 0. A later request to 0x0010 hits with 0xDEAD_BEEF in 1 cycle.
- Flush with request:
  - Stimulus: iIF_En and iFlush high in the same IDLE cycle.
  - Response: no oIF_En and no oMC_En.
- en stall and reset:
  - Stimulus: drop en to 0 during MISS while iMC_En is held off; then raise en. Separately, drop rst to 0 mid-miss.
  - Response: with en=0, state and oMC_En are held. rst=0 immediately forces oMC_En=0, clears valid, and the next request to a previously filled PC misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the data widths used by fetch and the controller state encoding.
package icache_pkg;

  localparam int REG_DAT_W = 32;
  localparam int INS_DAT_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  // Word-aligned memory address for a fetch PC.
  function automatic logic [REG_DAT_W-1:0] word_addr(input logic [REG_DAT_W-1:0] pc);
    return {pc[REG_DAT_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache.
// It has a combinational hit lookup and a single synchronous fill port.
module icache_array
  import icache_pkg::*;
#(
  parameter int IDX_W = 8,
  parameter int TAG_W = 32 - IDX_W - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     i_rd_idx,
  input  logic [TAG_W-1:0]     i_rd_tag,
  output logic                 o_hit,
  output logic [INS_DAT_W-1:0] o_rd_dat,
  input  logic                 i_wr_en,
  input  logic [IDX_W-1:0]     i_wr_idx,
  input  logic [TAG_W-1:0]     i_wr_tag,
  input  logic [INS_DAT_W-1:0] i_wr_dat
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]     r_valid;
  logic [TAG_W-1:0]     r_tag [LINES];
  logic [INS_DAT_W-1:0] r_dat [LINES];

  // Only the valid bits are cleared; stale tags and data are harmless once invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx] <= i_wr_tag;
      r_dat[i_wr_idx] <= i_wr_dat;
    end
  end

  assign o_hit    = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
  assign o_rd_dat = r_dat[i_rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the memory controller.
// A hit answers in one cycle; a miss fetches one word, fills the line and then answers.
module icache
  import icache_pkg::*;
#(
  parameter int IDX_W = 8,
  parameter int TAG_W = 32 - IDX_W - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 iIF_En,
  input  logic [REG_DAT_W-1:0] iIF_Pc,
  output logic                 oIF_En,
  output logic [INS_DAT_W-1:0] oIF_Ins,
  output logic                 oMC_En,
  output logic [REG_DAT_W-1:0] oMC_Addr,
  input  logic                 iMC_En,
  input  logic [INS_DAT_W-1:0] iMC_Dat,
  input  logic                 iFlush
);

  state_t r_state;
  logic   r_drop;

  logic                 w_hit;
  logic [INS_DAT_W-1:0] w_rd_dat;
  logic                 w_fill;
  logic                 w_unused;

  assign w_fill   = en && (r_state == MISS) && iMC_En;
  assign w_unused = &{1'b0, iIF_Pc[1:0], oMC_Addr[1:0]};

  // oMC_Addr doubles as the latched miss PC, so the fill index/tag come from it.
  icache_array #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .i_rd_idx (iIF_Pc[IDX_W+1:2]),
    .i_rd_tag (iIF_Pc[31:IDX_W+2]),
    .o_hit    (w_hit),
    .o_rd_dat (w_rd_dat),
    .i_wr_en  (w_fill),
    .i_wr_idx (oMC_Addr[IDX_W+1:2]),
    .i_wr_tag (oMC_Addr[31:IDX_W+2]),
    .i_wr_dat (iMC_Dat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_drop   <= 1'b0;
      oIF_En   <= 1'b0;
      oIF_Ins  <= '0;
      oMC_En   <= 1'b0;
      oMC_Addr <= '0;
    end else if (en) begin
      oIF_En <= 1'b0;
      case (r_state)
        IDLE: begin
          if (iIF_En && !iFlush) begin
            if (w_hit) begin
              oIF_En  <= 1'b1;
              oIF_Ins <= w_rd_dat;
            end else begin
              oMC_En   <= 1'b1;
              oMC_Addr <= word_addr(iIF_Pc);
              r_state  <= MISS;
            end
          end
        end
        MISS: begin
          if (iFlush) begin
            r_drop <= 1'b1;
          end
          // A flush arriving with the data still completes the fill but suppresses the answer.
          if (iMC_En) begin
            oMC_En  <= 1'b0;
            r_drop  <= 1'b0;
            r_state <= IDLE;
            if (!r_drop && !iFlush) begin
              oIF_En  <= 1'b1;
              oIF_Ins <= iMC_Dat;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
